// File: rtl/mux2_arbiter_if.sv
// Handshake bundle between the two sub-mode requesters and the output-mux arbiter.
interface mux2_arbiter_if;
  logic req0;
  logic req1;
  logic gnt0;
  logic gnt1;
  logic mux_sel;
  logic out_en;
  logic busy;

  // Requester side: drives requests, observes grants and mux routing.
  modport master (
    output req0, req1,
    input  gnt0, gnt1, mux_sel, out_en, busy
  );

  // Arbiter side.
  modport slave (
    input  req0, req1,
    output gnt0, gnt1, mux_sel, out_en, busy
  );
endinterface

// File: rtl/mux2_arbiter.sv
// Two-way output-mux arbiter: round-robin on ties, guard dead cycles between
// owners, optional preemption after a maximum hold time.
module mux2_arbiter #(
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned MAX_HOLD     = 255,
  parameter int unsigned CNT_W        = 8
) (
  input  logic          clk,
  input  logic          rst,
  mux2_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GUARD = 2'd1;
  localparam logic [1:0] S_OWN   = 2'd2;

  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam bit               GUARD_EN   = (GUARD_CYCLES != 0);
  localparam bit               PREEMPT_EN = (MAX_HOLD != 0);

  logic [1:0]       r_state;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_mux_sel;     // 1 routes requester 0; also identifies target/owner
  logic             r_out_en;
  logic             r_busy;
  logic             r_last_owner;  // index of the requester that last owned the output
  logic [CNT_W-1:0] r_guard_cnt;
  logic [CNT_W-1:0] r_hold_cnt;

  logic [1:0]       w_state_nxt;
  logic             w_gnt0_nxt;
  logic             w_gnt1_nxt;
  logic             w_mux_sel_nxt;
  logic             w_out_en_nxt;
  logic             w_busy_nxt;
  logic             w_last_owner_nxt;
  logic [CNT_W-1:0] w_guard_cnt_nxt;
  logic [CNT_W-1:0] w_hold_cnt_nxt;

  logic             w_tgt;         // requester index chosen in IDLE
  logic             w_own_req;
  logic             w_other_req;
  logic             w_preempt;

  // Target selection and owner/other request views relative to the current select.
  assign w_tgt       = (bus.req0 & bus.req1) ? ~r_last_owner : bus.req1;
  assign w_own_req   = r_mux_sel ? bus.req0 : bus.req1;
  assign w_other_req = r_mux_sel ? bus.req1 : bus.req0;
  assign w_preempt   = PREEMPT_EN && (r_hold_cnt >= HOLD_LIMIT) && w_other_req;

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_gnt0_nxt       = r_gnt0;
    w_gnt1_nxt       = r_gnt1;
    w_mux_sel_nxt    = r_mux_sel;
    w_last_owner_nxt = r_last_owner;
    w_guard_cnt_nxt  = r_guard_cnt;
    w_hold_cnt_nxt   = r_hold_cnt;

    case (r_state)
      S_IDLE: begin
        if (bus.req0 | bus.req1) begin
          w_mux_sel_nxt   = ~w_tgt;
          w_guard_cnt_nxt = GUARD_LOAD;
          w_hold_cnt_nxt  = '0;
          if (GUARD_EN) begin
            w_state_nxt = S_GUARD;
          end else begin
            w_state_nxt = S_OWN;
            w_gnt0_nxt  = ~w_tgt;
            w_gnt1_nxt  = w_tgt;
          end
        end
      end

      S_GUARD: begin
        if (!w_own_req) begin
          // Target withdrew before it was granted; last_owner stays as it was.
          w_state_nxt = S_IDLE;
        end else begin
          w_guard_cnt_nxt = r_guard_cnt - CNT_ONE;
          if (r_guard_cnt == CNT_ONE) begin
            w_state_nxt    = S_OWN;
            w_gnt0_nxt     = r_mux_sel;
            w_gnt1_nxt     = ~r_mux_sel;
            w_hold_cnt_nxt = '0;
          end
        end
      end

      S_OWN: begin
        if (r_hold_cnt != CNT_MAX) begin
          w_hold_cnt_nxt = r_hold_cnt + CNT_ONE;
        end
        // Release and preempt share the same exit; a simultaneous drop is just a release.
        if (!w_own_req || w_preempt) begin
          w_state_nxt      = S_IDLE;
          w_gnt0_nxt       = 1'b0;
          w_gnt1_nxt       = 1'b0;
          w_last_owner_nxt = ~r_mux_sel;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_gnt0_nxt  = 1'b0;
        w_gnt1_nxt  = 1'b0;
      end
    endcase

    w_out_en_nxt = w_gnt0_nxt | w_gnt1_nxt;
    w_busy_nxt   = (w_state_nxt != S_IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_mux_sel    <= 1'b1;
      r_out_en     <= 1'b0;
      r_busy       <= 1'b0;
      r_last_owner <= 1'b1;
      r_guard_cnt  <= '0;
      r_hold_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_gnt0       <= w_gnt0_nxt;
      r_gnt1       <= w_gnt1_nxt;
      r_mux_sel    <= w_mux_sel_nxt;
      r_out_en     <= w_out_en_nxt;
      r_busy       <= w_busy_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_guard_cnt  <= w_guard_cnt_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
    end
  end

  assign bus.gnt0    = r_gnt0;
  assign bus.gnt1    = r_gnt1;
  assign bus.mux_sel = r_mux_sel;
  assign bus.out_en  = r_out_en;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter: vector table on the default configuration plus
// hand sequences on preempt, zero-guard, async-reset and no-preempt variants.
module tb_mux2_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic r_req0;
  logic r_req1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mux2_arbiter_if if_a ();
  mux2_arbiter_if if_p ();
  mux2_arbiter_if if_z ();
  mux2_arbiter_if if_n ();

  assign if_a.req0 = r_req0;
  assign if_a.req1 = r_req1;
  assign if_p.req0 = r_req0;
  assign if_p.req1 = r_req1;
  assign if_z.req0 = r_req0;
  assign if_z.req1 = r_req1;
  assign if_n.req0 = r_req0;
  assign if_n.req1 = r_req1;

  mux2_arbiter #(.GUARD_CYCLES(4), .MAX_HOLD(255), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  mux2_arbiter #(.GUARD_CYCLES(4), .MAX_HOLD(8),   .CNT_W(8)) dut_p (.clk(clk), .rst(rst), .bus(if_p.slave));
  mux2_arbiter #(.GUARD_CYCLES(0), .MAX_HOLD(255), .CNT_W(8)) dut_z (.clk(clk), .rst(rst), .bus(if_z.slave));
  mux2_arbiter #(.GUARD_CYCLES(4), .MAX_HOLD(0),   .CNT_W(8)) dut_n (.clk(clk), .rst(rst), .bus(if_n.slave));

  // Output snapshots packed as {gnt0, gnt1, mux_sel, out_en, busy}.
  logic [4:0] w_a, w_z, w_n;
  assign w_a = {if_a.gnt0, if_a.gnt1, if_a.mux_sel, if_a.out_en, if_a.busy};
  assign w_z = {if_z.gnt0, if_z.gnt1, if_z.mux_sel, if_z.out_en, if_z.busy};
  assign w_n = {if_n.gnt0, if_n.gnt1, if_n.mux_sel, if_n.out_en, if_n.busy};

  localparam logic [4:0] IDL1 = 5'b00100;  // idle, requester 0 routed (also reset value)
  localparam logic [4:0] IDL0 = 5'b00000;  // idle, requester 1 routed
  localparam logic [4:0] GRD1 = 5'b00101;  // guard toward requester 0
  localparam logic [4:0] GRD0 = 5'b00001;  // guard toward requester 1
  localparam logic [4:0] OWN0 = 5'b10111;
  localparam logic [4:0] OWN1 = 5'b01011;

  typedef struct packed {
    logic       rst;
    logic       req0;
    logic       req1;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
  endfunction

  task automatic add(int n, logic r, logic a, logic b, logic [4:0] e);
    for (int i = 0; i < n; i++) tbl.push_back('{rst: r, req0: a, req1: b, exp: e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    r_req0 = 1'b0;
    r_req1 = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Grants mutually exclusive and out_en tracking the grants, every cycle on every instance.
  always @(negedge clk) begin
    check("inv_a", int'({if_a.gnt0 & if_a.gnt1, if_a.out_en ^ (if_a.gnt0 | if_a.gnt1)}), 0);
    check("inv_p", int'({if_p.gnt0 & if_p.gnt1, if_p.out_en ^ (if_p.gnt0 | if_p.gnt1)}), 0);
    check("inv_z", int'({if_z.gnt0 & if_z.gnt1, if_z.out_en ^ (if_z.gnt0 | if_z.gnt1)}), 0);
    check("inv_n", int'({if_n.gnt0 & if_n.gnt1, if_n.out_en ^ (if_n.gnt0 | if_n.gnt1)}), 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int m;

    // Single request, release, tie alternation, guard abort with tie afterwards.
    add(4, 0, 1, 0, GRD1);
    add(2, 0, 1, 0, OWN0);
    add(2, 0, 0, 0, IDL1);
    add(1, 1, 0, 0, IDL1);
    add(4, 0, 1, 1, GRD1);
    add(1, 0, 1, 1, OWN0);
    add(1, 0, 0, 1, IDL1);
    add(4, 0, 0, 1, GRD0);
    add(1, 0, 0, 1, OWN1);
    add(1, 0, 1, 1, OWN1);
    add(1, 0, 1, 0, IDL0);
    add(4, 0, 1, 1, GRD1);
    add(1, 0, 1, 1, OWN0);
    add(1, 0, 0, 0, IDL1);
    add(1, 1, 0, 0, IDL1);
    add(2, 0, 0, 1, GRD0);
    add(1, 0, 0, 0, IDL0);
    add(4, 0, 1, 1, GRD1);
    add(1, 0, 1, 1, OWN0);
    add(1, 0, 0, 0, IDL1);

    rst    = 1'b1;
    r_req0 = 1'b0;
    r_req1 = 1'b0;
    tick();
    tick();
    check("reset_state", int'(w_a), int'(IDL1));

    for (int i = 0; i < tbl.size(); i++) begin
      rst    = tbl[i].rst;
      r_req0 = tbl[i].req0;
      r_req1 = tbl[i].req1;
      tick();
      if (w_a !== tbl[i].exp)
        $display("FAIL vec%0d: got %b, expected %b (g0 g1 sel oe busy)", i, w_a, tbl[i].exp);
      n_total++;
      if (w_a === tbl[i].exp) n_pass++;
    end

    // Preemption with MAX_HOLD=8: req1 arrives in the owner's second cycle.
    do_reset();
    r_req0 = 1'b1;
    k = 0;
    while (!if_p.gnt0 && k < 20) begin
      tick();
      k++;
    end
    check("p_latency", k, 5);
    tick();
    r_req1 = 1'b1;
    k = 2;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!if_p.gnt0) break;
      k++;
    end
    check("p_hold_cycles", k, 9);
    m = 0;
    while (!if_p.gnt1 && m < 20) begin
      tick();
      m++;
    end
    check("p_gap", m, 5);
    check("p_mux_sel", int'(if_p.mux_sel), 0);

    // Zero guard: one-cycle grant.
    do_reset();
    r_req1 = 1'b1;
    tick();
    check("z_latency", int'(w_z), int'(OWN1));
    r_req1 = 1'b0;
    tick();
    check("z_release", int'(w_z), int'(IDL0));

    // Asynchronous reset mid-GUARD, re-grant, then mid-OWN.
    do_reset();
    r_req1 = 1'b1;
    tick();
    tick();
    check("c_in_guard", int'(w_a), int'(GRD0));
    #1 rst = 1'b1;
    #1 check("c_rst_guard", int'(w_a), int'(IDL1));
    #1 rst = 1'b0;
    r_req1 = 1'b0;
    r_req0 = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("c_regrant_guard", int'(w_a), int'(GRD1));
    tick();
    check("c_regrant", int'(w_a), int'(OWN0));
    #1 rst = 1'b1;
    #1 check("c_rst_own", int'(w_a), int'(IDL1));
    #1 rst = 1'b0;
    r_req0 = 1'b0;
    tick();

    // MAX_HOLD=0: long hold with a pending competitor is never preempted.
    do_reset();
    r_req0 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("n_grant", int'(w_n), int'(OWN0));
    r_req1 = 1'b1;
    k = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (if_n.gnt0 && !if_n.gnt1) k++;
    end
    check("n_no_preempt", k, 300);
    r_req0 = 1'b0;
    tick();
    check("n_release", int'(w_n), int'(IDL1));
    for (int i = 0; i < 5; i++) tick();
    check("n_next_owner", int'(w_n), int'(OWN1));
    r_req1 = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
